dsp_result_capture: RTL

DSP_RESULT_CAPTURE -- requirements
Module: dsp_result_capture

---
 rtl/dsp_result_capture.sv | 108 ++++++++++
 1 files changed

// File: rtl/dsp_result_capture.sv
// Captures DSP P results LAT cycles after operand acceptance into a credit-guarded
// first-word-fall-through FIFO, carrying a sideband tag alongside each result.
module dsp_result_capture #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [TAGW-1:0]              in_tag,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             P,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [TAGW-1:0]              out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic                  accept, pop, push, push_ok;
  logic [TAGW-1:0]       push_tag;
  logic [LW-1:0]         credits_q, credits_d, level_q, level_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic [WIDTH+TAGW-1:0] mem [DEPTH];

  assign in_ready  = (credits_q != '0);
  assign accept    = in_valid & in_ready;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign level     = level_q;
  assign ovf       = ovf_q;

  generate
    if (LAT == 0) begin : g_nolat
      assign push     = accept;
      assign push_tag = in_tag;
    end else begin : g_chain
      logic [LAT-1:0]  vld_q;
      logic [TAGW-1:0] tag_q [LAT];

      // Bubbles shift through as vld=0 so each result lines up with its own tag.
      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
          vld_q[0] <= accept;
          tag_q[0] <= in_tag;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end

      assign push     = vld_q[LAT-1];
      assign push_tag = tag_q[LAT-1];
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push_ok   = push & ((level_q != LW'(DEPTH)) | pop);
    credits_d = credits_q;
    level_d   = level_q;
    if (accept && !pop)      credits_d = credits_q - LW'(1);
    else if (pop && !accept) credits_d = credits_q + LW'(1);
    if (push_ok && !pop)     level_d = level_q + LW'(1);
    else if (pop && !push_ok) level_d = level_q - LW'(1);
    wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    ovf_d  = ovf_q | (push & ~push_ok);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      credits_q <= LW'(DEPTH);
      level_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      level_q   <= level_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is deliberately unreset; the output mux hides stale contents.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr_q] <= {P, push_tag};
  end

  assign {out_data, out_tag} = out_valid ? mem[rptr_q] : '0;

endmodule
